// File: rtl/ibex_custom_wr_buffer.sv
// Write buffer between the EX-stage S-box custom unit and the scratch-RAM write port.
// Define IBEX_CUSTOM_WB_FWD_EN to enable read-after-write forwarding from buffered entries.
module ibex_custom_wr_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wr_valid_i,
    input  logic [AW-1:0]              wr_addr_i,
    input  logic [DW-1:0]              wr_data_i,
    output logic                       wr_ready_o,
    input  logic [AW-1:0]              rd_addr_i,
    input  logic [DW-1:0]              ram_rdata_i,
    output logic [DW-1:0]              rd_data_o,
    output logic                       rd_hit_o,
    output logic                       ram_we_o,
    output logic [AW-1:0]              ram_waddr_o,
    output logic [DW-1:0]              ram_wdata_o,
    input  logic                       ram_gnt_i,
    input  logic                       flush_i,
    output logic                       flush_done_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_FLUSH} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [AW-1:0]   r_addr [DEPTH];
    logic [DW-1:0]   r_data [DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_next;
    logic            r_flush_done;
    logic            w_flush_done_next;
    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic            w_unused_rd;

    // Readiness uses the registered count, so a same-cycle pop never reopens a full buffer.
    assign w_full       = (r_count == CW'(DEPTH));
    assign wr_ready_o   = !w_full && (r_state != S_FLUSH);
    assign w_push       = wr_valid_i && wr_ready_o;
    assign ram_we_o     = (r_count != '0);
    assign w_pop        = ram_we_o && ram_gnt_i;
    assign ram_waddr_o  = r_addr[r_head];
    assign ram_wdata_o  = r_data[r_head];
    assign count_o      = r_count;
    assign flush_done_o = r_flush_done;
    assign w_unused_rd  = ^rd_addr_i;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CW'(1);
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - CW'(1);
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_flush_done_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (flush_i) begin
                    w_state_next = S_FLUSH;
                end else if (w_push) begin
                    w_state_next = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (flush_i) begin
                    w_state_next = S_FLUSH;
                end else if (w_count_next == '0) begin
                    w_state_next = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (w_count_next == '0) begin
                    w_state_next      = S_IDLE;
                    w_flush_done_next = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_flush_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_count      <= w_count_next;
            r_flush_done <= w_flush_done_next;
            if (w_push) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
        end
    end

    // Entry storage carries no reset; validity is defined purely by head/count.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_addr[r_tail] <= wr_addr_i;
            r_data[r_tail] <= wr_data_i;
        end
    end

`ifdef IBEX_CUSTOM_WB_FWD_EN
    logic            w_hit;
    logic [DW-1:0]   w_fwd_data;
    logic [PW-1:0]   w_idx;

    // Walk oldest to newest so the newest matching word-address entry wins.
    always_comb begin
        w_hit      = 1'b0;
        w_fwd_data = '0;
        w_idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PW'(i);
            if ((CW'(i) < r_count) && (r_addr[w_idx][AW-1:2] == rd_addr_i[AW-1:2])) begin
                w_hit      = 1'b1;
                w_fwd_data = r_data[w_idx];
            end
        end
    end

    assign rd_hit_o  = w_hit;
    assign rd_data_o = w_hit ? w_fwd_data : ram_rdata_i;
`else
    assign rd_hit_o  = 1'b0;
    assign rd_data_o = ram_rdata_i;
`endif

endmodule
